// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcode/funct fields, op_id encoding,
// execution unit and ROB entry type codes, and the slot state enum.
package decode_stage_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [5:0] OPID_NOP   = 6'd0;
  localparam logic [5:0] OPID_LUI   = 6'd1;
  localparam logic [5:0] OPID_AUIPC = 6'd2;
  localparam logic [5:0] OPID_JAL   = 6'd3;
  localparam logic [5:0] OPID_JALR  = 6'd4;
  localparam logic [5:0] OPID_BEQ   = 6'd5;
  localparam logic [5:0] OPID_BNE   = 6'd6;
  localparam logic [5:0] OPID_BLT   = 6'd7;
  localparam logic [5:0] OPID_BGE   = 6'd8;
  localparam logic [5:0] OPID_BLTU  = 6'd9;
  localparam logic [5:0] OPID_BGEU  = 6'd10;
  localparam logic [5:0] OPID_LB    = 6'd11;
  localparam logic [5:0] OPID_LH    = 6'd12;
  localparam logic [5:0] OPID_LW    = 6'd13;
  localparam logic [5:0] OPID_LBU   = 6'd14;
  localparam logic [5:0] OPID_LHU   = 6'd15;
  localparam logic [5:0] OPID_SB    = 6'd16;
  localparam logic [5:0] OPID_SH    = 6'd17;
  localparam logic [5:0] OPID_SW    = 6'd18;
  localparam logic [5:0] OPID_ADDI  = 6'd19;
  localparam logic [5:0] OPID_SLTI  = 6'd20;
  localparam logic [5:0] OPID_SLTIU = 6'd21;
  localparam logic [5:0] OPID_XORI  = 6'd22;
  localparam logic [5:0] OPID_ORI   = 6'd23;
  localparam logic [5:0] OPID_ANDI  = 6'd24;
  localparam logic [5:0] OPID_SLLI  = 6'd25;
  localparam logic [5:0] OPID_SRLI  = 6'd26;
  localparam logic [5:0] OPID_SRAI  = 6'd27;
  localparam logic [5:0] OPID_ADD   = 6'd28;
  localparam logic [5:0] OPID_SUB   = 6'd29;
  localparam logic [5:0] OPID_SLL   = 6'd30;
  localparam logic [5:0] OPID_SLT   = 6'd31;
  localparam logic [5:0] OPID_SLTU  = 6'd32;
  localparam logic [5:0] OPID_XOR   = 6'd33;
  localparam logic [5:0] OPID_SRL   = 6'd34;
  localparam logic [5:0] OPID_SRA   = 6'd35;
  localparam logic [5:0] OPID_OR    = 6'd36;
  localparam logic [5:0] OPID_AND   = 6'd37;

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_BR   = 2'd1,
    UNIT_LSB  = 2'd2,
    UNIT_NONE = 2'd3
  } unit_e;

  typedef enum logic [2:0] {
    ROBTYPE_REG     = 3'd0,
    ROBTYPE_BRANCH  = 3'd1,
    ROBTYPE_STORE   = 3'd2,
    ROBTYPE_LOAD    = 3'd3,
    ROBTYPE_JUMP    = 3'd4,
    ROBTYPE_ILLEGAL = 3'd5
  } robtype_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/decode_stage_comb.sv
// decode_comb: purely combinational RV32I decoder. Unknown encodings raise
// illegal_o and present the trap view (unit NONE, rob type ILLEGAL, NOP,
// all register indices and valids zero).
module decode_comb import decode_stage_pkg::*; #(
  parameter int IMM_W  = 32,
  parameter int OPID_W = 6
) (
  input  logic [31:0]       inst_i,
  output logic              illegal_o,
  output logic [1:0]        unit_o,
  output logic [OPID_W-1:0] op_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic              rdValid_o,
  output logic              rs1Valid_o,
  output logic              rs2Valid_o,
  output logic [2:0]        robType_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rdIdx, rs1Idx, rs2Idx;
  logic [IMM_W-1:0] immI, immS, immB, immU, immJ, immShamt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rdIdx  = inst_i[11:7];
  assign rs1Idx = inst_i[19:15];
  assign rs2Idx = inst_i[24:20];

  assign immI     = IMM_W'($signed(inst_i[31:20]));
  assign immS     = IMM_W'($signed({inst_i[31:25], inst_i[11:7]}));
  assign immB     = IMM_W'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign immU     = IMM_W'($signed({inst_i[31:12], 12'h000}));
  assign immJ     = IMM_W'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign immShamt = IMM_W'(inst_i[24:20]);

  logic       illegal, useRd, useRs1, useRs2;
  logic [5:0] opSel;
  logic [1:0] unitSel;
  logic [2:0] robSel;
  logic [IMM_W-1:0] immSel;

  // Classify the opcode, pick the immediate format and the op_id, and flag
  // any encoding outside RV32I base integer as illegal.
  always_comb begin
    illegal = 1'b0;
    useRd   = 1'b0;
    useRs1  = 1'b0;
    useRs2  = 1'b0;
    opSel   = OPID_NOP;
    unitSel = UNIT_ALU;
    robSel  = ROBTYPE_REG;
    immSel  = '0;
    case (opcode)
      OPCODE_LUI: begin
        opSel = OPID_LUI; immSel = immU; useRd = 1'b1;
      end
      OPCODE_AUIPC: begin
        opSel = OPID_AUIPC; immSel = immU; useRd = 1'b1;
      end
      OPCODE_JAL: begin
        opSel = OPID_JAL; unitSel = UNIT_BR; robSel = ROBTYPE_JUMP;
        immSel = immJ; useRd = 1'b1;
      end
      OPCODE_JALR: begin
        opSel = OPID_JALR; unitSel = UNIT_BR; robSel = ROBTYPE_JUMP;
        immSel = immI; useRd = 1'b1; useRs1 = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPCODE_BRANCH: begin
        unitSel = UNIT_BR; robSel = ROBTYPE_BRANCH; immSel = immB;
        useRs1 = 1'b1; useRs2 = 1'b1;
        case (funct3)
          3'b000:  opSel = OPID_BEQ;
          3'b001:  opSel = OPID_BNE;
          3'b100:  opSel = OPID_BLT;
          3'b101:  opSel = OPID_BGE;
          3'b110:  opSel = OPID_BLTU;
          3'b111:  opSel = OPID_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        unitSel = UNIT_LSB; robSel = ROBTYPE_LOAD; immSel = immI;
        useRd = 1'b1; useRs1 = 1'b1;
        case (funct3)
          3'b000:  opSel = OPID_LB;
          3'b001:  opSel = OPID_LH;
          3'b010:  opSel = OPID_LW;
          3'b100:  opSel = OPID_LBU;
          3'b101:  opSel = OPID_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPCODE_STORE: begin
        unitSel = UNIT_LSB; robSel = ROBTYPE_STORE; immSel = immS;
        useRs1 = 1'b1; useRs2 = 1'b1;
        case (funct3)
          3'b000:  opSel = OPID_SB;
          3'b001:  opSel = OPID_SH;
          3'b010:  opSel = OPID_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPCODE_OPIMM: begin
        immSel = immI; useRd = 1'b1; useRs1 = 1'b1;
        case (funct3)
          3'b000: opSel = OPID_ADDI;
          3'b010: opSel = OPID_SLTI;
          3'b011: opSel = OPID_SLTIU;
          3'b100: opSel = OPID_XORI;
          3'b110: opSel = OPID_ORI;
          3'b111: opSel = OPID_ANDI;
          3'b001: begin
            opSel = OPID_SLLI; immSel = immShamt;
            illegal = (funct7 != FUNCT7_BASE);
          end
          default: begin
            opSel = inst_i[30] ? OPID_SRAI : OPID_SRLI; immSel = immShamt;
            illegal = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
          end
        endcase
      end
      OPCODE_OP: begin
        useRd = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          case (funct3)
            3'b000:  opSel = OPID_ADD;
            3'b001:  opSel = OPID_SLL;
            3'b010:  opSel = OPID_SLT;
            3'b011:  opSel = OPID_SLTU;
            3'b100:  opSel = OPID_XOR;
            3'b101:  opSel = OPID_SRL;
            3'b110:  opSel = OPID_OR;
            default: opSel = OPID_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          opSel = OPID_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
          opSel = OPID_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Drive unused indices to zero and replace everything with the trap view
  // when the encoding is illegal.
  always_comb begin
    illegal_o  = illegal;
    unit_o     = illegal ? UNIT_NONE : unitSel;
    op_o       = illegal ? OPID_W'(OPID_NOP) : OPID_W'(opSel);
    imm_o      = illegal ? '0 : immSel;
    robType_o  = illegal ? ROBTYPE_ILLEGAL : robSel;
    rdValid_o  = !illegal && useRd && (rdIdx != 5'd0);
    rs1Valid_o = !illegal && useRs1;
    rs2Valid_o = !illegal && useRs2;
    rd_o       = rdValid_o  ? rdIdx  : 5'd0;
    rs1_o      = rs1Valid_o ? rs1Idx : 5'd0;
    rs2_o      = rs2Valid_o ? rs2Idx : 5'd0;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-slot registered decode between InstQueue and the
// Dispatcher/ROB/RegFile. Optional macro ILLEGAL_TRAP_EN keeps illegal
// instructions in the slot and dispatches them to the ROB only; without it
// they are popped and dropped.
module decode_stage import decode_stage_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 32,
  parameter int TAG_W  = 4,
  parameter int OPID_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              iq_valid,
  input  logic [31:0]       iq_inst,
  input  logic [ADDR_W-1:0] iq_pc,
  output logic              iq_pop,
  input  logic              rob_full,
  input  logic              alu_rs_full,
  input  logic              br_rs_full,
  input  logic              lsb_rs_full,
  input  logic [TAG_W-1:0]  rob_tag,
  output logic              disp_fire,
  output logic              out_valid,
  output logic [1:0]        out_unit,
  output logic [OPID_W-1:0] out_op_id,
  output logic [ADDR_W-1:0] out_pc,
  output logic [IMM_W-1:0]  out_imm,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic              out_rd_valid,
  output logic              out_rs1_valid,
  output logic              out_rs2_valid,
  output logic [2:0]        out_rob_type,
  output logic [TAG_W-1:0]  out_rd_tag,
  output logic              out_illegal
);

  typedef struct packed {
    logic [1:0]        unit;
    logic [OPID_W-1:0] op;
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rdValid;
    logic              rs1Valid;
    logic              rs2Valid;
    logic [2:0]        robType;
  } slot_t;

  localparam slot_t SLOT_CLEAR = '{unit: UNIT_NONE, default: '0};

  slot_t decoded, slot_d, slot_q;
  slot_e state_d, state_q;
  logic  decIllegal, unitFull, fire, load, capture;

  decode_comb #(
    .IMM_W  (IMM_W),
    .OPID_W (OPID_W)
  ) u_decode (
    .inst_i     (iq_inst),
    .illegal_o  (decIllegal),
    .unit_o     (decoded.unit),
    .op_o       (decoded.op),
    .imm_o      (decoded.imm),
    .rd_o       (decoded.rd),
    .rs1_o      (decoded.rs1),
    .rs2_o      (decoded.rs2),
    .rdValid_o  (decoded.rdValid),
    .rs1Valid_o (decoded.rs1Valid),
    .rs2Valid_o (decoded.rs2Valid),
    .robType_o  (decoded.robType)
  );
  assign decoded.pc = iq_pc;

  // Handshake: the slot fires when its target unit and the ROB have room,
  // and refills from the queue whenever it is empty or leaving this cycle.
  always_comb begin
    case (slot_q.unit)
      UNIT_ALU: unitFull = alu_rs_full;
      UNIT_BR:  unitFull = br_rs_full;
      UNIT_LSB: unitFull = lsb_rs_full;
      default:  unitFull = 1'b0;
    endcase
    fire = rdy && (state_q == SLOT_FULL) && !flush && !rob_full && !unitFull;
    load = rdy && !flush && iq_valid && ((state_q == SLOT_EMPTY) || fire);
`ifdef ILLEGAL_TRAP_EN
    capture = load;
`else
    capture = load && !decIllegal;
`endif
  end

  // Slot occupancy next state; flush wins, a dropped illegal pop or a fire
  // with nothing captured leaves the slot empty.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SLOT_EMPTY;
    end else if (capture) begin
      state_d = SLOT_FULL;
    end else if (fire || load) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot payload next value: new instruction on capture, cleared when empty.
  always_comb begin
    slot_d = slot_q;
    if (capture) begin
      slot_d = decoded;
    end else if (state_d == SLOT_EMPTY) begin
      slot_d = SLOT_CLEAR;
    end
  end

  // Slot state and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      slot_q  <= SLOT_CLEAR;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Illegal flag travels with the slot payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (capture) begin
      illegal_q <= decIllegal;
    end else if (state_d == SLOT_EMPTY) begin
      illegal_q <= 1'b0;
    end
  end
  assign out_illegal = illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign iq_pop        = load;
  assign disp_fire     = fire;
  assign out_rd_tag    = fire ? rob_tag : '0;
  assign out_valid     = (state_q == SLOT_FULL);
  assign out_unit      = slot_q.unit;
  assign out_op_id     = slot_q.op;
  assign out_pc        = slot_q.pc;
  assign out_imm       = slot_q.imm;
  assign out_rd        = slot_q.rd;
  assign out_rs1       = slot_q.rs1;
  assign out_rs2       = slot_q.rs2;
  assign out_rd_valid  = slot_q.rdValid;
  assign out_rs1_valid = slot_q.rs1Valid;
  assign out_rs2_valid = slot_q.rs2Valid;
  assign out_rob_type  = slot_q.robType;

endmodule
